// File: rtl/tap_ctrl_param.sv
// IEEE 1149.1 TAP controller with a parametrised instruction register and
// BYPASS, IDCODE and NUM_USER user data registers on the TDI/TDO scan path.
module tap_ctrl_param #(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int          NUM_USER   = 2,
    parameter int          USER_W     = 8
) (
    input  logic                         GCLK_Pad,
    input  logic                         TRST_Pad,
    input  logic                         TMS_Pad,
    input  logic                         TDI_Pad,
    output logic                         TDO_Pad,
    output logic                         TDO_en_Pad,
    output logic [3:0]                   state_obs_Pad,
    output logic [IR_W-1:0]              ir_Pad,
    input  logic [NUM_USER*USER_W-1:0]   user_cap_i,
    output logic [NUM_USER*USER_W-1:0]   user_q_o,
    output logic [NUM_USER-1:0]          user_upd_o
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } state_t;

    localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0] OP_BYPASS = '1;
    // Wide enough to compare user opcodes without truncating them.
    localparam int CW = (IR_W > 8) ? IR_W : 8;

    state_t                       state_reg;
    state_t                       state_next;
    logic [IR_W-1:0]              ir_reg;
    logic [IR_W-1:0]              ir_shift_reg;
    logic [IR_W-1:0]              ir_shifted;
    logic [IR_W:0]                ir_cat;
    logic                         bypass_reg;
    logic [31:0]                  id_shift_reg;
    logic [NUM_USER*USER_W-1:0]   user_shift_reg;
    logic [NUM_USER*USER_W-1:0]   user_shifted;
    logic [NUM_USER*USER_W-1:0]   user_q_reg;
    logic [NUM_USER-1:0]          user_upd_reg;
    logic [NUM_USER-1:0]          user_tdo_bits;
    logic [NUM_USER-1:0]          sel_user;
    logic                         sel_idcode;
    logic                         sel_bypass;
    logic [CW-1:0]                ir_wide;
    logic                         dr_tdo;

    assign ir_wide    = CW'(ir_reg);
    assign sel_idcode = (ir_reg == OP_IDCODE);
    assign sel_bypass = !sel_idcode && !(|sel_user);

    assign ir_cat     = {TDI_Pad, ir_shift_reg};
    assign ir_shifted = ir_cat[IR_W:1];

    generate
        for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user
            logic [USER_W:0] cat;
            assign sel_user[gi] = (ir_reg != OP_BYPASS) && (ir_wide == CW'(gi + 2));
            assign cat = {TDI_Pad, user_shift_reg[gi*USER_W +: USER_W]};
            assign user_shifted[gi*USER_W +: USER_W] = cat[USER_W:1];
            assign user_tdo_bits[gi] = user_shift_reg[gi*USER_W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TLR:     state_next = TMS_Pad ? TLR    : RTI;
            RTI:     state_next = TMS_Pad ? SEL_DR : RTI;
            SEL_DR:  state_next = TMS_Pad ? SEL_IR : CAP_DR;
            CAP_DR:  state_next = TMS_Pad ? EX1_DR : SH_DR;
            SH_DR:   state_next = TMS_Pad ? EX1_DR : SH_DR;
            EX1_DR:  state_next = TMS_Pad ? UPD_DR : PAU_DR;
            PAU_DR:  state_next = TMS_Pad ? EX2_DR : PAU_DR;
            EX2_DR:  state_next = TMS_Pad ? UPD_DR : SH_DR;
            UPD_DR:  state_next = TMS_Pad ? SEL_DR : RTI;
            SEL_IR:  state_next = TMS_Pad ? TLR    : CAP_IR;
            CAP_IR:  state_next = TMS_Pad ? EX1_IR : SH_IR;
            SH_IR:   state_next = TMS_Pad ? EX1_IR : SH_IR;
            EX1_IR:  state_next = TMS_Pad ? UPD_IR : PAU_IR;
            PAU_IR:  state_next = TMS_Pad ? EX2_IR : PAU_IR;
            EX2_IR:  state_next = TMS_Pad ? UPD_IR : SH_IR;
            UPD_IR:  state_next = TMS_Pad ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // At most one user select is active, so OR-reducing the masked bits picks it.
    always_comb begin
        dr_tdo = bypass_reg;
        if (sel_idcode) begin
            dr_tdo = id_shift_reg[0];
        end else if (|sel_user) begin
            dr_tdo = |(sel_user & user_tdo_bits);
        end
    end

    always_comb begin
        TDO_Pad = 1'b0;
        if (state_reg == SH_IR) begin
            TDO_Pad = ir_shift_reg[0];
        end else if (state_reg == SH_DR) begin
            TDO_Pad = dr_tdo;
        end
    end

    assign TDO_en_Pad    = (state_reg == SH_DR) || (state_reg == SH_IR);
    assign state_obs_Pad = state_reg;
    assign ir_Pad        = ir_reg;
    assign user_q_o      = user_q_reg;
    assign user_upd_o    = user_upd_reg;

    always_ff @(posedge GCLK_Pad) begin
        if (!TRST_Pad) begin
            state_reg      <= TLR;
            ir_reg         <= OP_IDCODE;
            ir_shift_reg   <= '0;
            bypass_reg     <= 1'b0;
            id_shift_reg   <= '0;
            user_shift_reg <= '0;
            user_q_reg     <= '0;
            user_upd_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            user_upd_reg <= '0;

            if (state_next == TLR) begin
                ir_reg <= OP_IDCODE;
            end else if (state_reg == UPD_IR) begin
                ir_reg <= ir_shift_reg;
            end

            case (state_reg)
                CAP_IR: ir_shift_reg <= IR_W'(1);
                SH_IR:  ir_shift_reg <= ir_shifted;
                CAP_DR: begin
                    if (sel_bypass) bypass_reg   <= 1'b0;
                    if (sel_idcode) id_shift_reg <= IDCODE_VAL;
                    for (int k = 0; k < NUM_USER; k++) begin
                        if (sel_user[k])
                            user_shift_reg[k*USER_W +: USER_W] <= user_cap_i[k*USER_W +: USER_W];
                    end
                end
                SH_DR: begin
                    if (sel_bypass) bypass_reg   <= TDI_Pad;
                    if (sel_idcode) id_shift_reg <= {TDI_Pad, id_shift_reg[31:1]};
                    for (int k = 0; k < NUM_USER; k++) begin
                        if (sel_user[k])
                            user_shift_reg[k*USER_W +: USER_W] <= user_shifted[k*USER_W +: USER_W];
                    end
                end
                UPD_DR: begin
                    for (int k = 0; k < NUM_USER; k++) begin
                        if (sel_user[k]) begin
                            user_q_reg[k*USER_W +: USER_W] <= user_shift_reg[k*USER_W +: USER_W];
                            user_upd_reg[k]                <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Self-checking bench for tap_ctrl_param: a table of TMS/TDI steps with expected
// state, plus scan sequences whose expected TDO bits flow through a scoreboard queue.
module tb_tap_ctrl_param;

    localparam int          IR_W       = 4;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
    localparam int          NUM_USER   = 2;
    localparam int          USER_W     = 8;

    typedef struct packed {
        logic            tms;
        logic            tdi;
        logic [3:0]      st;
        logic            en;
        logic [IR_W-1:0] ir;
        logic            tdo;
    } vec_t;

    logic                       clk;
    logic                       trst;
    logic                       tms;
    logic                       tdi;
    logic                       tdo;
    logic                       tdo_en;
    logic [3:0]                 state_obs;
    logic [IR_W-1:0]            ir;
    logic [NUM_USER*USER_W-1:0] user_cap;
    logic [NUM_USER*USER_W-1:0] user_q;
    logic [NUM_USER-1:0]        user_upd;

    int   n_cmp;
    int   n_err;
    logic exp_q[$];
    vec_t vecs[24];

    tap_ctrl_param #(
        .IR_W(IR_W), .IDCODE_VAL(IDCODE_VAL), .NUM_USER(NUM_USER), .USER_W(USER_W)
    ) dut (
        .GCLK_Pad(clk),
        .TRST_Pad(trst),
        .TMS_Pad(tms),
        .TDI_Pad(tdi),
        .TDO_Pad(tdo),
        .TDO_en_Pad(tdo_en),
        .state_obs_Pad(state_obs),
        .ir_Pad(ir),
        .user_cap_i(user_cap),
        .user_q_o(user_q),
        .user_upd_o(user_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
    endtask

    // Compare the bit currently on TDO against the scoreboard, then clock one shift.
    task automatic shift_bit(input logic t, input logic d, input string nm);
        logic e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got tdo=%0b with empty scoreboard, required an expectation", nm, tdo);
        end else begin
            e = exp_q.pop_front();
            check(nm, 64'(tdo), 64'(e));
        end
        step(t, d);
    endtask

    // RTI -> shift IR_W bits of val -> UpdIR -> RTI; checks the 0..01 capture pattern.
    task automatic load_ir(input logic [IR_W-1:0] val);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IR_W; i++) exp_q.push_back(i == 0);
        for (int i = 0; i < IR_W; i++) shift_bit(i == IR_W - 1, val[i], "ir_capture");
        step(1, 0); step(0, 0);
        check("ir_load", 64'(ir), 64'(val));
        $display("load_ir %0h -> ir=%0h", val, ir);
    endtask

    // RTI -> CapDR -> shift n bits of data -> stops in UpdDR.
    task automatic shift_dr(input int n, input logic [63:0] data, input string nm);
        step(1, 0); step(0, 0); step(0, 0);
        check({nm, "_in_shdr"}, 64'(state_obs), 64'h2);
        for (int i = 0; i < n; i++) shift_bit(i == n - 1, data[i], nm);
        step(1, 0);
        check({nm, "_updr"}, 64'(state_obs), 64'h5);
        $display("shift_dr %s n=%0d data=%0h", nm, n, data);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [3:0]  exp_seq[5];

        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{1'b0, 1'b0, 4'hC, 1'b0, 4'h1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h6, 1'b0, 4'h1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h2, 1'b1, 4'h1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 4'h1, 1'b0, 4'h1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'h2, 1'b1, 4'h1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'h1, 1'b0, 4'h1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'h5, 1'b0, 4'h1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'h4, 1'b0, 4'h1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'hE, 1'b0, 4'h1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'hA, 1'b1, 4'h1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 4'h9, 1'b0, 4'h1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'hB, 1'b0, 4'h1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'h8, 1'b0, 4'h1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 4'hA, 1'b1, 4'h1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 4'h9, 1'b0, 4'h1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 4'hD, 1'b0, 4'h1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 4'hC, 1'b0, 4'h4, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 4'h7, 1'b0, 4'h4, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 4'h4, 1'b0, 4'h4, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 4'hF, 1'b0, 4'h1, 1'b0};

        trst     = 1'b0;
        tms      = 1'b0;
        tdi      = 1'b0;
        user_cap = '0;

        // Reset held for three clocks
        repeat (3) step(0, 0);
        check("reset_state", 64'(state_obs), 64'hF);
        check("reset_ir", 64'(ir), 64'h1);
        check("reset_user_q", 64'(user_q), 64'h0);
        check("reset_upd", 64'(user_upd), 64'h0);
        check("reset_tdo_en", 64'(tdo_en), 64'h0);
        check("reset_tdo", 64'(tdo), 64'h0);
        $display("reset -> state=%0h ir=%0h", state_obs, ir);
        trst = 1'b1;

        // Walk every state, including Pause/Exit holds and an IR update + TLR restore
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].tms, vecs[i].tdi);
            check($sformatf("walk%0d_state", i), 64'(state_obs), 64'(vecs[i].st));
            check($sformatf("walk%0d_tdo_en", i), 64'(tdo_en), 64'(vecs[i].en));
            check($sformatf("walk%0d_ir", i), 64'(ir), 64'(vecs[i].ir));
            check($sformatf("walk%0d_tdo", i), 64'(tdo), 64'(vecs[i].tdo));
            $display("walk %0d tms=%0b tdi=%0b -> state=%0h ir=%0h tdo=%0b",
                     i, vecs[i].tms, vecs[i].tdi, state_obs, ir, tdo);
        end

        // IDCODE out LSB-first, then the TDI bits that entered at bit 31
        rnd = $urandom();
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        check("id_in_shdr", 64'(state_obs), 64'h2);
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE_VAL[i]);
        for (int i = 0; i < 32; i++) exp_q.push_back(rnd[i]);
        for (int i = 0; i < 64; i++) shift_bit(i == 63, (i < 32) ? rnd[i] : 1'b0, "idcode");
        check("id_ex1dr", 64'(state_obs), 64'h1);
        step(1, 0); step(0, 0);
        check("id_no_upd", 64'(user_upd), 64'h0);
        $display("idcode scan done rnd=%08h", rnd);

        // BYPASS: explicit all-ones opcode, then an unassigned opcode
        load_ir(4'hF);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        shift_dr(4, 64'b1101, "bypass_f");
        step(0, 0);
        check("bypass_f_no_upd", 64'(user_upd), 64'h0);
        load_ir(4'h6);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
        shift_dr(3, 64'b011, "bypass_6");
        step(0, 0);

        // USER 0 and USER 1 capture, shift and update strobes
        user_cap = {8'h3C, 8'h96};
        load_ir(4'h2);
        for (int i = 0; i < 8; i++) exp_q.push_back(((8'h96 >> i) & 8'h1) != 0);
        shift_dr(8, 64'hA5, "user0");
        step(0, 0);
        check("user0_q", 64'(user_q), 64'h00A5);
        check("user0_upd", 64'(user_upd), 64'h1);
        step(0, 0);
        check("user0_upd_clear", 64'(user_upd), 64'h0);
        check("user0_q_hold", 64'(user_q), 64'h00A5);

        load_ir(4'h3);
        for (int i = 0; i < 8; i++) exp_q.push_back(((8'h3C >> i) & 8'h1) != 0);
        shift_dr(8, 64'h5A, "user1");
        step(0, 0);
        check("user1_q", 64'(user_q), 64'h5AA5);
        check("user1_upd", 64'(user_upd), 64'h2);
        step(0, 0);
        check("user1_upd_clear", 64'(user_upd), 64'h0);

        // From Shift-DR five TMS=1 edges reach TLR; IR returns to IDCODE
        load_ir(4'h2);
        step(1, 0); step(0, 0); step(0, 0);
        check("tlr5_shdr", 64'(state_obs), 64'h2);
        exp_seq[0] = 4'h1; exp_seq[1] = 4'h5; exp_seq[2] = 4'h7;
        exp_seq[3] = 4'h4; exp_seq[4] = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            check($sformatf("tlr5_state%0d", i), 64'(state_obs), 64'(exp_seq[i]));
            if (i == 2) begin
                check("tlr5_upd", 64'(user_upd), 64'h1);
                check("tlr5_user_q", 64'(user_q), 64'h5A4B);
            end
            $display("tlr5 step %0d -> state=%0h", i, state_obs);
        end
        check("tlr5_ir", 64'(ir), 64'h1);

        // TRST pulse in the middle of Shift-IR
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        check("trst_in_shir", 64'(state_obs), 64'hA);
        check("trst_shir_tdo", 64'(tdo), 64'h1);
        step(0, 1); step(0, 1);
        trst = 1'b0;
        step(0, 0);
        trst = 1'b1;
        check("trst_state", 64'(state_obs), 64'hF);
        check("trst_ir", 64'(ir), 64'h1);
        check("trst_tdo_en", 64'(tdo_en), 64'h0);
        check("trst_tdo", 64'(tdo), 64'h0);
        check("trst_user_q", 64'(user_q), 64'h0);
        $display("trst mid shift-ir -> state=%0h ir=%0h", state_obs, ir);
        step(0, 0);
        load_ir(4'h3);

        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
